// File: rtl/cpu_control_unit.sv
// Sequencer and execute stage for the instruction ROM: fetches, executes against an
// 8x16 register file, and advances the ROM with a registered one-cycle step pulse.
module cpu_control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [8:0]  instruction,
  input  logic [15:0] data_var,
  output logic        step,
  output logic        busy,
  output logic        done,
  output logic        carry,
  output logic        zero,
  output logic        illegal,
  output logic [7:0]  instr_count,
  input  logic [2:0]  dbg_sel,
  output logic [15:0] dbg_data
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, STEP, HALT} state_t;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOVE = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_TERM = 3'b100;

  state_t      state_reg, state_next;
  logic [8:0]  ir_reg;
  logic [15:0] dr_reg;
  logic [15:0] regs_reg [8];
  logic        step_reg;
  logic        carry_reg;
  logic        zero_reg;
  logic        illegal_reg;
  logic [7:0]  count_reg;

  logic [2:0]  opcode, rx, ry;
  logic [15:0] op_a, op_b, xor_res, wr_data;
  logic [16:0] sum;
  logic        exec_fire;
  logic        wr_en;
  logic [7:0]  wr_sel;

  assign opcode  = ir_reg[8:6];
  assign rx      = ir_reg[5:3];
  assign ry      = ir_reg[2:0];
  // Both operands come from the pre-write file, so Rx == Ry behaves naturally
  assign op_a    = regs_reg[rx];
  assign op_b    = regs_reg[ry];
  assign sum     = {1'b0, op_a} + {1'b0, op_b};
  assign xor_res = op_a ^ op_b;

  assign exec_fire = (state_reg == EXEC) && (opcode != OP_TERM);

  always_comb begin
    state_next = state_reg;
    wr_en      = 1'b0;
    wr_data    = dr_reg;
    case (state_reg)
      IDLE:    if (run) state_next = FETCH;
      FETCH:   state_next = EXEC;
      EXEC:    state_next = (opcode == OP_TERM) ? HALT : STEP;
      STEP:    state_next = FETCH;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
    case (opcode)
      OP_LOAD: begin wr_en = exec_fire; wr_data = dr_reg;        end
      OP_MOVE: begin wr_en = exec_fire; wr_data = op_b;          end
      OP_ADD:  begin wr_en = exec_fire; wr_data = sum[15:0];     end
      OP_XOR:  begin wr_en = exec_fire; wr_data = xor_res;       end
      default: begin wr_en = 1'b0;      wr_data = dr_reg;        end
    endcase
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_en && (rx == 3'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_sel[i]) regs_reg[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ir_reg      <= '0;
      dr_reg      <= '0;
      step_reg    <= 1'b0;
      carry_reg   <= 1'b0;
      zero_reg    <= 1'b0;
      illegal_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg <= state_next;
      // The ROM clocks on this, so it must come straight from a flop
      step_reg  <= exec_fire;
      if (state_reg == FETCH) begin
        ir_reg <= instruction;
        dr_reg <= data_var;
      end
      if (exec_fire) begin
        count_reg <= count_reg + 8'd1;
        case (opcode)
          OP_ADD: begin
            carry_reg <= sum[16];
            zero_reg  <= (sum[15:0] == 16'h0000);
          end
          OP_XOR:  zero_reg <= (xor_res == 16'h0000);
          OP_LOAD, OP_MOVE: ;
          default: illegal_reg <= 1'b1;
        endcase
      end
    end
  end

  assign step        = step_reg;
  assign busy        = (state_reg == FETCH) || (state_reg == EXEC) || (state_reg == STEP);
  assign done        = (state_reg == HALT);
  assign carry       = carry_reg;
  assign zero        = zero_reg;
  assign illegal     = illegal_reg;
  assign instr_count = count_reg;
  assign dbg_data    = regs_reg[dbg_sel];

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: stub ROM advanced by step, a cycle-count based
// reference model compared every cycle, plus literal expectations per scenario.
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        rst_n, run, rom_rst;
  logic [8:0]  instruction;
  logic [15:0] data_var;
  logic [2:0]  dbg_sel;
  logic        step, busy, done, carry, zero, illegal;
  logic [7:0]  instr_count;
  logic [15:0] dbg_data;

  int n_checks = 0;
  int n_errors = 0;
  logic check_en = 1'b0;

  cpu_control_unit dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .instruction(instruction), .data_var(data_var),
    .step(step), .busy(busy), .done(done), .carry(carry), .zero(zero),
    .illegal(illegal), .instr_count(instr_count),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Stub ROM: no reset of its own, address advanced by step, rewound only by rom_rst
  logic [8:0]  rom_ins [32];
  logic [15:0] rom_dat [32];
  logic [4:0]  rom_base = '0;
  logic [4:0]  rom_off = '0;
  int          step_pulses = 0;

  always @(posedge step or posedge rom_rst) begin
    if (rom_rst) rom_off <= '0;
    else         rom_off <= rom_off + 5'd1;
  end
  assign instruction = rom_ins[rom_base + rom_off];
  assign data_var    = rom_dat[rom_base + rom_off];

  always @(posedge step) begin
    step_pulses <= step_pulses + 1;
    $display("retire t=%0t ins=%b data=%h count_after=%0d", $time, dut.ir_reg, dut.dr_reg, instr_count);
  end

  // Reference model: m_t counts edges since FETCH entry; the instruction retires on
  // every edge where m_t becomes 2 mod 3.
  logic        m_act = 1'b0, m_halt = 1'b0, m_step = 1'b0;
  logic        m_carry = 1'b0, m_zero = 1'b0, m_ill = 1'b0;
  logic [7:0]  m_cnt = '0;
  int          m_t = 0;
  logic [4:0]  m_off = '0;
  logic [15:0] m_r [8];
  logic [8:0]  m_ins;
  logic [2:0]  m_op, m_rx, m_ry;
  logic [16:0] m_sum;

  assign m_ins = rom_ins[rom_base + m_off];
  assign m_op  = m_ins[8:6];
  assign m_rx  = m_ins[5:3];
  assign m_ry  = m_ins[2:0];
  assign m_sum = {1'b0, m_r[m_rx]} + {1'b0, m_r[m_ry]};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0; m_halt <= 1'b0; m_step <= 1'b0; m_t <= 0;
      m_carry <= 1'b0; m_zero <= 1'b0; m_ill <= 1'b0; m_cnt <= '0;
      for (int i = 0; i < 8; i++) m_r[i] <= '0;
    end else begin
      m_step <= 1'b0;
      if (rom_rst) m_off <= '0;
      if (m_act) begin
        m_t <= m_t + 1;
        if ((m_t % 3) == 1) begin
          if (m_op == 3'd4) begin
            m_act  <= 1'b0;
            m_halt <= 1'b1;
          end else begin
            m_step <= 1'b1;
            m_cnt  <= m_cnt + 8'd1;
            m_off  <= m_off + 5'd1;
            case (m_op)
              3'd0: m_r[m_rx] <= rom_dat[rom_base + m_off];
              3'd1: m_r[m_rx] <= m_r[m_ry];
              3'd2: begin
                m_r[m_rx] <= m_sum[15:0];
                m_carry   <= m_sum[16];
                m_zero    <= (m_sum[15:0] == 16'h0000);
              end
              3'd3: begin
                m_r[m_rx] <= m_r[m_rx] ^ m_r[m_ry];
                m_zero    <= ((m_r[m_rx] ^ m_r[m_ry]) == 16'h0000);
              end
              default: m_ill <= 1'b1;
            endcase
          end
        end
      end else if (!m_halt && run) begin
        m_act <= 1'b1;
        m_t   <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_step",    16'(step),        16'(m_step));
      chk("cyc_busy",    16'(busy),        16'(m_act));
      chk("cyc_done",    16'(done),        16'(m_halt));
      chk("cyc_carry",   16'(carry),       16'(m_carry));
      chk("cyc_zero",    16'(zero),        16'(m_zero));
      chk("cyc_illegal", 16'(illegal),     16'(m_ill));
      chk("cyc_count",   16'(instr_count), 16'(m_cnt));
      chk("cyc_dbg",     dbg_data,         m_r[dbg_sel]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      dbg_sel = dbg_sel + 3'd1;
    end
  endtask

  task automatic reinit(input logic [4:0] base);
    rom_base = base;
    rom_rst  = 1'b1;
    cyc(1);
    rom_rst  = 1'b0;
    cyc(1);
  endtask

  task automatic start();
    run = 1'b1;
    @(posedge clk);
    #2;
    run = 1'b0;
  endtask

  task automatic wait_done(input int bound, input int run_at, output int lat);
    lat = 0;
    while (!done && lat < bound) begin
      @(posedge clk);
      #2;
      lat++;
      run = (lat == run_at);
      dbg_sel = dbg_sel + 3'd1;
    end
    run = 1'b0;
    if (!done) chk("done_timeout", 16'(done), 16'd1);
  endtask

  task automatic rd(input string name, input logic [2:0] sel, input logic [15:0] exp);
    dbg_sel = sel;
    #1;
    chk(name, dbg_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, p0, n, seen;
    rst_n = 1'b0; run = 1'b0; rom_rst = 1'b0; dbg_sel = '0;
    for (int i = 0; i < 32; i++) begin
      rom_ins[i] = 9'b100_000_000;
      rom_dat[i] = 16'h0000;
    end
    // Program 1: load r0,5; load r1,4; add r1,r0; move r6,r0; xor r6,r1; terminate
    rom_ins[0] = 9'b000_000_000; rom_dat[0] = 16'd5;
    rom_ins[1] = 9'b000_001_000; rom_dat[1] = 16'd4;
    rom_ins[2] = 9'b010_001_000;
    rom_ins[3] = 9'b001_110_000;
    rom_ins[4] = 9'b011_110_001;
    rom_ins[5] = 9'b100_000_000;
    // Program 2: overflow, self-xor, illegal opcode, trailing load
    rom_ins[8]  = 9'b000_010_000; rom_dat[8]  = 16'hFFFF;
    rom_ins[9]  = 9'b000_011_000; rom_dat[9]  = 16'h0002;
    rom_ins[10] = 9'b010_010_011;
    rom_ins[11] = 9'b011_010_010;
    rom_ins[12] = 9'b101_000_000; rom_dat[12] = 16'hDEAD;
    rom_ins[13] = 9'b000_100_000; rom_dat[13] = 16'h1234;
    rom_ins[14] = 9'b100_000_000;
    // Program 3: interrupted by reset after its second instruction, then resumed at 18
    rom_ins[16] = 9'b000_101_000; rom_dat[16] = 16'hABCD;
    rom_ins[17] = 9'b000_111_000; rom_dat[17] = 16'h0077;
    rom_ins[18] = 9'b000_001_000; rom_dat[18] = 16'h0042;
    rom_ins[19] = 9'b100_000_000;

    cyc(2);
    chk("rst_step", 16'(step), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_flags", {13'd0, carry, zero, illegal}, 16'd0);
    chk("rst_count", 16'(instr_count), 16'd0);
    chk("rst_dbg", dbg_data, 16'h0000);
    check_en = 1'b1;
    cyc(1);
    rst_n = 1'b1;
    reinit(5'd0);

    // Program 1 with a stray run pulse mid-program
    p0 = step_pulses;
    start();
    wait_done(100, 4, lat);
    chk("p1_done_latency", 16'(lat), 16'd17);
    rd("p1_r0", 3'd0, 16'd5);
    rd("p1_r1", 3'd1, 16'd9);
    rd("p1_r6", 3'd6, 16'h000C);
    chk("p1_count", 16'(instr_count), 16'd5);
    chk("p1_carry_zero", {14'd0, carry, zero}, 16'd0);
    chk("p1_steps", 16'(step_pulses - p0), 16'd5);

    // HALT holds against run toggling
    for (int i = 0; i < 20; i++) begin
      run = ~run;
      cyc(1);
    end
    run = 1'b0;
    chk("halt_steps", 16'(step_pulses - p0), 16'd5);
    chk("halt_done", 16'(done), 16'd1);
    chk("halt_count", 16'(instr_count), 16'd5);

    // Program 2
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    reinit(5'd8);
    p0 = step_pulses;
    start();
    n = 0;
    while ((step_pulses - p0) < 3 && n < 50) begin
      cyc(1);
      n++;
    end
    rd("p2_add_r2", 3'd2, 16'h0001);
    chk("p2_add_flags", {14'd0, carry, zero}, 16'b10);
    wait_done(100, -1, lat);
    rd("p2_xor_r2", 3'd2, 16'h0000);
    rd("p2_r3", 3'd3, 16'h0002);
    rd("p2_r4", 3'd4, 16'h1234);
    rd("p2_r0", 3'd0, 16'h0000);
    chk("p2_flags", {13'd0, carry, zero, illegal}, 16'b111);
    chk("p2_count", 16'(instr_count), 16'd6);
    chk("p2_steps", 16'(step_pulses - p0), 16'd6);

    // Program 3: reset while step is high
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    reinit(5'd16);
    start();
    n = 0; seen = 0;
    while (seen < 2 && n < 50) begin
      cyc(1);
      n++;
      if (step) seen++;
    end
    chk("p3_step_seen", 16'(seen), 16'd2);
    rst_n = 1'b0;
    #1;
    chk("p3_rst_step", 16'(step), 16'd0);
    chk("p3_rst_busy", 16'(busy), 16'd0);
    chk("p3_rst_count", 16'(instr_count), 16'd0);
    rd("p3_rst_r5", 3'd5, 16'h0000);
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    chk("p3_idle_busy", 16'(busy), 16'd0);
    chk("p3_idle_done", 16'(done), 16'd0);
    p0 = step_pulses;
    start();
    wait_done(100, -1, lat);
    rd("p3_r1", 3'd1, 16'h0042);
    rd("p3_r5", 3'd5, 16'h0000);
    rd("p3_r7", 3'd7, 16'h0000);
    chk("p3_count", 16'(instr_count), 16'd1);
    chk("p3_steps", 16'(step_pulses - p0), 16'd1);
    cyc(2);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
